// File: rtl/mem_rw_pipe_helper.sv
// Word RAM with a valid/ready read channel (READ_LATENCY-cycle pipeline into a credit-limited response FIFO) and a write channel.
// Reads stall on credits (outstanding >= RESP_DEPTH); writes stall only on enable. Out-of-range accesses are flagged and counted.
module mem_rw_pipe_helper #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 27,
  parameter int DEPTH        = 2**ADDR_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  r_req_valid,
  output logic                  r_req_ready,
  input  logic [ADDR_WIDTH-1:0] r_req_index,
  output logic                  r_resp_valid,
  input  logic                  r_resp_ready,
  output logic [DATA_WIDTH-1:0] r_resp_data,
  output logic                  r_resp_err,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_index,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] w_mask,
  output logic                  w_err,
  output logic [15:0]           err_count
);

  localparam int MA = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] dat;
  } resp_t;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic          rst_done;
  logic [CW-1:0] outst;
  logic          r_acc, w_acc, r_in_range, w_in_range, pop, push;
  resp_t         rd_entry, push_entry, head;

  assign w_ready     = enable & rst_done;
  assign r_req_ready = enable & rst_done & (outst < CW'(RESP_DEPTH));
  assign r_acc       = r_req_valid & r_req_ready;
  assign w_acc       = w_valid & w_ready;
  assign r_in_range  = {1'b0, r_req_index} < DEPTH_L;
  assign w_in_range  = {1'b0, w_index} < DEPTH_L;

  // Sampled before the same-edge write lands, giving read-before-write on collisions.
  assign rd_entry.err = ~r_in_range;
  assign rd_entry.dat = r_in_range ? ram[r_req_index[MA-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (w_acc && w_in_range)
      ram[w_index[MA-1:0]] <= (w_data & w_mask) | (ram[w_index[MA-1:0]] & ~w_mask);
  end

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign push       = r_acc;
      assign push_entry = rd_entry;
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] pipe_vld;
      resp_t                   pipe_dat [READ_LATENCY-1];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          pipe_vld <= '0;
          for (int i = 0; i < READ_LATENCY-1; i++) pipe_dat[i] <= '0;
        end else begin
          pipe_vld[0] <= r_acc;
          pipe_dat[0] <= rd_entry;
          for (int i = 1; i < READ_LATENCY-1; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
          end
        end
      end

      assign push       = pipe_vld[READ_LATENCY-2];
      assign push_entry = pipe_dat[READ_LATENCY-2];
    end
  endgenerate

  resp_t         fifo_mem [RESP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign head         = fifo_mem[rd_ptr];
  assign r_resp_valid = (fifo_cnt != '0);
  assign r_resp_data  = r_resp_valid ? head.dat : '0;
  assign r_resp_err   = r_resp_valid & head.err;
  assign pop          = r_resp_valid & r_resp_ready;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = {1'b0, r_acc & ~r_in_range} + {1'b0, w_acc & ~w_in_range};
  assign err_sum = {1'b0, err_count} + 17'(err_inc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_done  <= 1'b0;
      outst     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      w_err     <= 1'b0;
      err_count <= '0;
    end else begin
      rst_done  <= 1'b1;
      // Credits freed by a handshake only become visible to r_req_ready next cycle.
      outst     <= outst + CW'(r_acc) - CW'(pop);
      fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      w_err     <= w_acc & ~w_in_range;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_mem_rw_pipe_helper.sv
// Randomized and directed bench for mem_rw_pipe_helper against a transaction-level model.
module tb_mem_rw_pipe_helper;

  localparam int DW    = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 40;
  localparam int LAT   = 2;
  localparam int RD    = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          r_req_valid = 1'b0;
  logic          r_req_ready;
  logic [AW-1:0] r_req_index = '0;
  logic          r_resp_valid;
  logic          r_resp_ready = 1'b0;
  logic [DW-1:0] r_resp_data;
  logic          r_resp_err;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [AW-1:0] w_index = '0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] w_mask = '0;
  logic          w_err;
  logic [15:0]   err_count;

  mem_rw_pipe_helper #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(LAT), .RESP_DEPTH(RD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_index(r_req_index),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready),
    .r_resp_data(r_resp_data), .r_resp_err(r_resp_err),
    .w_valid(w_valid), .w_ready(w_ready), .w_index(w_index),
    .w_data(w_data), .w_mask(w_mask), .w_err(w_err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  // Outstanding reads: every accepted read stays here until its response handshake.
  typedef struct {
    logic [DW-1:0] d;
    bit            err;
    int            vis;
  } rec_t;

  rec_t          rq[$];
  logic [DW-1:0] mdl_mem [DEPTH];
  int            edge_no = 0;
  bit            released = 0;
  bit            exp_werr = 0;
  int            exp_errs = 0;
  bit            obs_racc;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are set at a falling edge; outputs are compared 1ns later, then the model advances on the rising edge.
  task automatic step();
    bit            exp_wrdy, exp_rrdy, exp_vld, pop, racc, wacc;
    logic [AW-1:0] ri, wi;
    logic [DW-1:0] wd, wm;
    #1;
    exp_wrdy = enable && released && reset_n;
    exp_rrdy = exp_wrdy && (rq.size() < RD);
    exp_vld  = 0;
    if (reset_n && rq.size() > 0) exp_vld = (rq[0].vis <= edge_no);
    check("r_req_ready", DW'(r_req_ready), DW'(exp_rrdy));
    check("w_ready", DW'(w_ready), DW'(exp_wrdy));
    check("r_resp_valid", DW'(r_resp_valid), DW'(exp_vld));
    if (exp_vld) begin
      check("r_resp_data", r_resp_data, rq[0].d);
      check("r_resp_err", DW'(r_resp_err), DW'(rq[0].err));
    end
    check("w_err", DW'(w_err), DW'(exp_werr));
    check("err_count", DW'(err_count), DW'(exp_errs > 65535 ? 65535 : exp_errs));
    obs_racc = r_req_valid && r_req_ready;
    pop  = exp_vld && r_resp_ready;
    racc = r_req_valid && exp_rrdy;
    wacc = w_valid && exp_wrdy;
    ri = r_req_index; wi = w_index; wd = w_data; wm = w_mask;
    @(posedge clock);
    if (reset_n) begin
      edge_no++;
      if (pop) void'(rq.pop_front());
      if (racc) begin
        rec_t r;
        r.err = (int'(ri) >= DEPTH);
        r.d   = r.err ? '0 : mdl_mem[ri];
        r.vis = edge_no + LAT - 1;
        rq.push_back(r);
        if (r.err) exp_errs++;
      end
      exp_werr = wacc && (int'(wi) >= DEPTH);
      if (wacc && !exp_werr) mdl_mem[wi] = (wd & wm) | (mdl_mem[wi] & ~wm);
      if (exp_werr) exp_errs++;
      released = 1;
    end
    @(negedge clock);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    rq.delete();
    released = 0;
    exp_werr = 0;
    exp_errs = 0;
  endtask

  task automatic idle(input int n);
    r_req_valid = 1'b0;
    w_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] d, input logic [DW-1:0] m);
    w_valid = 1'b1; w_index = AW'(idx); w_data = d; w_mask = m;
  endtask

  task automatic rd(input int idx);
    r_req_valid = 1'b1; r_req_index = AW'(idx);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    @(negedge clock);
    assert_reset();
    #1;
    check("rst_resp_data", r_resp_data, '0);
    check("rst_resp_err", DW'(r_resp_err), '0);
    step(); step();
    reset_n = 1'b1;
    enable = 1'b1;
    r_resp_ready = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) begin
      wr(i, (i == 9) ? 64'h0 : 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0001_0001_0001, '1);
      step();
    end
    idle(1);

    // Full-mask write then read; response visible LAT-1 edges after accept.
    wr(5, 64'h1122334455667788, '1); step(); idle(1);
    rd(5); step(); r_req_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) step();
    check("t1_vld", DW'(r_resp_valid), 64'd1);
    check("t1_data", r_resp_data, 64'h1122334455667788);
    check("t1_err", DW'(r_resp_err), 64'd0);
    idle(2);

    wr(5, '1, 64'h0000_0000_FFFF_0000); step(); idle(1);
    rd(5); step(); r_req_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) step();
    check("t2_data", r_resp_data, 64'h11223344FFFF7788);
    idle(2);

    // Same-edge collision returns old data; a later read sees the write.
    wr(9, 64'hA, '1); rd(9); step(); idle(0); r_req_valid = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) step();
    check("t3_old", r_resp_data, 64'h0);
    idle(1);
    rd(9); step(); r_req_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) step();
    check("t3_new", r_resp_data, 64'hA);
    idle(2);

    // Credit limit with the consumer stalled.
    r_resp_ready = 1'b0;
    acc = 0;
    rd(10);
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_racc) begin acc++; r_req_index = AW'(10 + acc); end
    end
    check("t4_accepted", 64'(acc), 64'd4);
    check("t4_ready_low", DW'(r_req_ready), 64'd0);
    r_resp_ready = 1'b1;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      step();
      if (obs_racc) begin acc++; r_req_index = AW'(10 + acc); end
    end
    check("t4_all_accepted", 64'(acc), 64'd6);
    idle(6);

    // Out-of-range read and write on the same edge.
    rd(DEPTH); wr(DEPTH + 1, 64'hDEAD, '1); step();
    r_req_valid = 1'b0; w_valid = 1'b0;
    check("t5_werr", DW'(w_err), 64'd1);
    check("t5_errcnt", DW'(err_count), 64'd2);
    for (int i = 0; i < LAT - 2; i++) step();
    step();
    check("t5_resp_err", DW'(r_resp_err), 64'd1);
    check("t5_resp_data", r_resp_data, 64'd0);
    idle(3);

    // Reset with reads in flight: all dropped.
    wr(20, 64'h5555_6666_7777_8888, '1); step(); w_valid = 1'b0;
    r_resp_ready = 1'b0;
    rd(1); step(); rd(2); step(); rd(3); step();
    r_req_valid = 1'b0;
    assert_reset();
    #1;
    check("t6_rst_vld", DW'(r_resp_valid), 64'd0);
    check("t6_rst_rdy", DW'(r_req_ready), 64'd0);
    step(); step();
    reset_n = 1'b1;
    r_resp_ready = 1'b1;
    step();
    check("t6_rdy_after", DW'(r_req_ready), 64'd1);
    check("t6_no_resp", DW'(r_resp_valid), 64'd0);
    idle(4);
    rd(20); step(); r_req_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) step();
    check("t6_persist", r_resp_data, 64'h5555_6666_7777_8888);
    idle(2);

    for (int c = 0; c < 800; c++) begin
      enable       = ($urandom_range(0, 9) != 0);
      r_req_valid  = ($urandom_range(0, 2) != 0);
      r_req_index  = AW'($urandom_range(0, DEPTH + 7));
      r_resp_ready = ($urandom_range(0, 3) != 0);
      w_valid      = ($urandom_range(0, 1) != 0);
      w_index      = AW'($urandom_range(0, DEPTH + 7));
      w_data       = {$urandom, $urandom};
      w_mask       = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
      step();
    end
    enable = 1'b1;
    r_resp_ready = 1'b1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
